// File: rtl/tri_period_sequencer.sv
// Sequences 11-bit triangle periods into the generator's nibble-wide
// LSEL/HSEL/HHSEL registers. The period can be loaded at once or reached by
// gliding one step at a time toward a target.
//
// Request handshake: a request transfers on a rising CLK edge where
// REQ_VALID && REQ_READY. REQ_READY depends only on the registered state,
// never on REQ_VALID. REQ_PERIOD and REQ_GLIDE are sampled on that edge only.
module tri_period_sequencer #(
  parameter int RATE_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [10:0]       REQ_PERIOD,
  input  logic [RATE_W-1:0] REQ_GLIDE,
  input  logic              TICK,
  output logic [3:0]        DIN,
  output logic              LSEL,
  output logic              HSEL,
  output logic              HHSEL,
  output logic              RST_C,
  output logic              BUSY,
  output logic [10:0]       CUR_PERIOD,
  output logic [2:0]        dbgState
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_L       = 3'd1,
    WR_H       = 3'd2,
    WR_HH      = 3'd3,
    RESTART    = 3'd4,
    GLIDE_WAIT = 3'd5
  } state_t;

  localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);

  state_t            state, stateNext;
  logic [10:0]       cur, curNext;
  logic [10:0]       target, targetNext;
  logic [RATE_W-1:0] rate, rateNext;
  logic [RATE_W-1:0] tcnt, tcntNext;
  logic              imm, immNext;
  logic              reqAccept;

  assign REQ_READY  = (state == IDLE) || (state == GLIDE_WAIT);
  assign reqAccept  = REQ_VALID && REQ_READY;
  assign CUR_PERIOD = cur;
  assign dbgState   = state;

  // State register; reset aborts any write sequence at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cur    <= '0;
      target <= '0;
      rate   <= '0;
      tcnt   <= '0;
      imm    <= 1'b0;
    end else begin
      state  <= stateNext;
      cur    <= curNext;
      target <= targetNext;
      rate   <= rateNext;
      tcnt   <= tcntNext;
      imm    <= immNext;
    end
  end

  // Next-state logic: accepts, glide timebase counting and write sequencing.
  always_comb begin
    stateNext  = state;
    curNext    = cur;
    targetNext = target;
    rateNext   = rate;
    tcntNext   = tcnt;
    immNext    = imm;
    unique case (state)
      IDLE, GLIDE_WAIT: begin
        if (reqAccept) begin
          // A retarget wins over a same-cycle tick; the tick is dropped.
          targetNext = REQ_PERIOD;
          if (REQ_GLIDE == '0) begin
            curNext   = REQ_PERIOD;
            immNext   = 1'b1;
            stateNext = WR_L;
          end else begin
            rateNext  = REQ_GLIDE;
            tcntNext  = '0;
            immNext   = 1'b0;
            stateNext = (REQ_PERIOD == cur) ? IDLE : GLIDE_WAIT;
          end
        end else if ((state == GLIDE_WAIT) && TICK) begin
          if (tcnt == rate - RATE_ONE) begin
            tcntNext  = '0;
            curNext   = (target > cur) ? cur + 11'd1 : cur - 11'd1;
            stateNext = WR_L;
          end else begin
            tcntNext = tcnt + RATE_ONE;
          end
        end
      end
      WR_L:  stateNext = WR_H;
      WR_H:  stateNext = WR_HH;
      WR_HH: begin
        if (imm) begin
          stateNext = RESTART;
        end else if (cur == target) begin
          stateNext = IDLE;
        end else begin
          tcntNext  = '0;
          stateNext = GLIDE_WAIT;
        end
      end
      RESTART: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output decode of the registered state; one strobe at most per cycle.
  always_comb begin
    DIN   = 4'h0;
    LSEL  = 1'b0;
    HSEL  = 1'b0;
    HHSEL = 1'b0;
    RST_C = 1'b0;
    BUSY  = (state != IDLE);
    unique case (state)
      WR_L: begin
        DIN  = cur[3:0];
        LSEL = 1'b1;
      end
      WR_H: begin
        DIN  = cur[7:4];
        HSEL = 1'b1;
      end
      WR_HH: begin
        DIN   = {1'b0, cur[10:8]};
        HHSEL = 1'b1;
      end
      RESTART: RST_C = 1'b1;
      default: DIN = 4'h0;
    endcase
  end

endmodule

// File: tb/tb_tri_period_sequencer.sv
// Bench for tri_period_sequencer: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// write-queue model of the sequencer.
module tb_tri_period_sequencer;

  localparam int RATE_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              reqValid = 1'b0;
  logic              reqReady;
  logic [10:0]       reqPeriod = '0;
  logic [RATE_W-1:0] reqGlide = '0;
  logic              tick = 1'b0;
  logic [3:0]        din;
  logic              lsel, hsel, hhsel, rstC, busy;
  logic [10:0]       curPeriod;
  logic [2:0]        dbgState;

  tri_period_sequencer #(.RATE_W(RATE_W)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(reqValid), .REQ_READY(reqReady),
    .REQ_PERIOD(reqPeriod), .REQ_GLIDE(reqGlide), .TICK(tick),
    .DIN(din), .LSEL(lsel), .HSEL(hsel), .HHSEL(hhsel), .RST_C(rstC),
    .BUSY(busy), .CUR_PERIOD(curPeriod), .dbgState(dbgState)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending output cycles: {rstc, hhsel, hsel, lsel, din}.
  logic [7:0]  exp_q[$];
  logic [10:0] mCur = '0;
  logic [10:0] mTarget = '0;
  int          mRate = 0;
  int          mCnt = 0;
  bit          mGliding = 1'b0;

  function automatic void pushWrites(input logic [10:0] p, input bit withRst);
    exp_q.push_back({4'b0001, p[3:0]});
    exp_q.push_back({4'b0010, p[7:4]});
    exp_q.push_back({4'b0100, 1'b0, p[10:8]});
    if (withRst) exp_q.push_back(8'b1000_0000);
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mCur = '0; mTarget = '0; mRate = 0; mCnt = 0; mGliding = 1'b0;
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end else if (reqValid) begin
      mTarget = reqPeriod;
      if (reqGlide == 0) begin
        mCur = reqPeriod;
        mGliding = 1'b0;
        pushWrites(mCur, 1'b1);
      end else begin
        mRate = int'(reqGlide);
        mCnt = 0;
        mGliding = (reqPeriod != mCur);
      end
    end else if (mGliding && tick) begin
      mCnt++;
      if (mCnt == mRate) begin
        mCnt = 0;
        if (mTarget > mCur) mCur = mCur + 11'd1;
        else mCur = mCur - 11'd1;
        pushWrites(mCur, 1'b0);
        if (mCur == mTarget) mGliding = 1'b0;
      end
    end
  end

  // ---------------- scoreboard compare + strobe counters ----------------
  int lselCnt = 0, hselCnt = 0, hhselCnt = 0, rstcCnt = 0;

  initial forever begin
    logic [7:0] e;
    int eReady, eBusy;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q[0]; eReady = 0; eBusy = 1;
    end else begin
      e = 8'h00; eReady = 1; eBusy = int'(mGliding);
    end
    chk("din", din, e[3:0]);
    chk("strobes", {rstC, hhsel, hsel, lsel}, e[7:4]);
    chk("req_ready", reqReady, eReady);
    chk("busy", busy, eBusy);
    chk("cur_period", curPeriod, mCur);
    lselCnt += lsel; hselCnt += hsel; hhselCnt += hhsel; rstcCnt += rstC;
  end

  // ---------------- tick driver ----------------
  int tickMode = 3;  // 1 periodic, 2 random, 3 driven by main process
  int tickPer = 5;
  int phase = 0;
  initial forever begin
    @(posedge clk); #1;
    phase++;
    if (tickMode == 1) tick = (phase % tickPer == 0);
    else if (tickMode == 2) tick = ($urandom_range(0, 1) == 1);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sendReq(input logic [10:0] p, input logic [RATE_W-1:0] g);
    reqValid = 1'b1; reqPeriod = p; reqGlide = g;
    step();
    reqValid = 1'b0;
  endtask

  task automatic waitIdle(input int maxCyc);
    int n = 0;
    while ((busy || !reqReady) && n < maxCyc) begin
      step(); n++;
    end
    chk("wait_idle_busy", busy, 0);
  endtask

  task automatic chkImmediate(input string nm, input logic [10:0] p);
    logic [10:0] pv;
    pv = p;
    chk({nm, "_lsel"}, lsel, 1); chk({nm, "_din_l"}, din, pv[3:0]);
    chk({nm, "_cur"}, curPeriod, pv);
    step();
    chk({nm, "_hsel"}, hsel, 1); chk({nm, "_din_h"}, din, pv[7:4]);
    step();
    chk({nm, "_hhsel"}, hhsel, 1); chk({nm, "_din_hh"}, din, {1'b0, pv[10:8]});
    step();
    chk({nm, "_rstc"}, rstC, 1);
    step();
    chk({nm, "_ready_back"}, reqReady, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int h0, r0, s0;
    // Reset held while inputs wiggle.
    step();
    for (int i = 0; i < 4; i++) begin
      reqValid = i[0]; tick = ~tick; reqPeriod = 11'($urandom); reqGlide = 8'(i);
      step();
      chk("rst_ready", reqReady, 1); chk("rst_busy", busy, 0);
      chk("rst_strobes", {rstC, hhsel, hsel, lsel}, 0); chk("rst_cur", curPeriod, 0);
    end
    reqValid = 1'b0; tick = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rst_ready", reqReady, 1); chk("post_rst_busy", busy, 0);

    // Immediate load, twice with the same period.
    sendReq(11'h5A3, 8'd0);
    chkImmediate("imm1", 11'h5A3);
    sendReq(11'h5A3, 8'd0);
    chkImmediate("imm2", 11'h5A3);
    chk("imm_din_pin_l", 11'h5A3 & 11'hF, 3);

    // Upward glide 0x010 -> 0x013, then downward to 0x011.
    sendReq(11'h010, 8'd0);
    waitIdle(10);
    h0 = hhselCnt; r0 = rstcCnt;
    tickMode = 1; tickPer = 5;
    sendReq(11'h013, 8'd2);
    waitIdle(200);
    chk("glide_up_cur", curPeriod, 11'h013);
    chk("glide_up_writes", hhselCnt - h0, 3);
    chk("glide_up_rstc", rstcCnt - r0, 0);
    h0 = hhselCnt; r0 = rstcCnt;
    sendReq(11'h011, 8'd2);
    waitIdle(200);
    chk("glide_dn_cur", curPeriod, 11'h011);
    chk("glide_dn_writes", hhselCnt - h0, 2);
    chk("glide_dn_rstc", rstcCnt - r0, 0);

    // Retarget on the same cycle as a terminal tick.
    tickMode = 3; tick = 1'b0;
    step();
    sendReq(11'h015, 8'd2);
    chk("rt_gliding", busy, 1); chk("rt_ready", reqReady, 1);
    tick = 1'b1;
    step();
    reqValid = 1'b1; reqPeriod = 11'h7FF; reqGlide = 8'd0;
    step();
    reqValid = 1'b0; tick = 1'b0;
    chkImmediate("retarget", 11'h7FF);
    chk("rt_din_pin", 15, 4'hF);

    // Glide request to the current period: accepted, nothing written.
    s0 = lselCnt + hselCnt + hhselCnt + rstcCnt;
    sendReq(11'h7FF, 8'd4);
    chk("same_ready", reqReady, 1); chk("same_busy", busy, 0);
    repeat (3) step();
    chk("same_no_strobes", lselCnt + hselCnt + hhselCnt + rstcCnt - s0, 0);

    // Reset in the middle of a write sequence.
    sendReq(11'h123, 8'd0);
    step();
    chk("mid_hsel_before", hsel, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_hsel_drop", hsel, 0); chk("mid_cur", curPeriod, 0); chk("mid_din", din, 0);
    step(); step();
    rst = 1'b0;
    h0 = hhselCnt;
    repeat (5) step();
    chk("mid_no_hhsel", hhselCnt - h0, 0);

    // Randomized phase.
    tickMode = 2;
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) begin
        reqValid = 1'b1;
        if ($urandom_range(0, 7) == 0) begin
          reqPeriod = 11'($urandom); reqGlide = 8'd0;
        end else begin
          int t;
          t = int'(mCur) + int'($urandom_range(0, 12)) - 6;
          if (t < 0) t = 0;
          if (t > 2047) t = 2047;
          reqPeriod = 11'(t);
          reqGlide = 8'($urandom_range(0, 3));
        end
      end else begin
        reqValid = 1'b0;
      end
      step();
    end
    reqValid = 1'b0;
    tickMode = 1; tickPer = 2;
    waitIdle(1000);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
